// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath defaults, architectural register
// names and the slicing helper for flattened multi-port buses.
package cpu_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;

    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;

    // LSB position of field idx in a bus built from w-bit fields.
    function automatic int unsigned field_lsb(
        input int unsigned idx,
        input int unsigned w
    );
        return idx * w;
    endfunction

endpackage

// File: rtl/busy_scoreboard.sv
// Per-register busy tracking for long-latency results: busy vector,
// running busy count, sticky protocol-error flag and per-port stalls.
module busy_scoreboard
    import cpu_pkg::*;
#(
    parameter int  NUM_REGS = NUM_REGS_DEF,
    parameter int  NUM_RD   = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_RD*AW-1:0] rd_addr,
    input  logic                 wb_we,
    input  logic [AW-1:0]        wb_addr,
    input  logic                 mark_en,
    input  logic [AW-1:0]        mark_addr,
    output logic [NUM_RD-1:0]    rd_busy,
    output logic [AW:0]          busy_cnt,
    output logic                 sb_err
);

    localparam bit            ZR       = (ZERO_REG != 0);
    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [AW:0]         busy_cnt_q, busy_cnt_d;
    logic                sb_err_q, sb_err_d;

    logic          mark_ok;
    logic          clr_ok;
    logic          same;
    logic          inc;
    logic          dec;
    logic [AW-1:0] ra;

    always_comb begin
        mark_ok = mark_en && !(ZR && mark_addr == ZERO_IDX);
        clr_ok  = wb_we && !(ZR && wb_addr == ZERO_IDX);
        same    = mark_ok && clr_ok && (mark_addr == wb_addr);

        // A same-cycle mark overrides the clear: the new producer wins.
        busy_d = busy_q;
        if (clr_ok) busy_d[wb_addr] = 1'b0;
        if (mark_ok) busy_d[mark_addr] = 1'b1;

        inc = mark_ok && !busy_q[mark_addr];
        dec = clr_ok && busy_q[wb_addr] && !same;

        busy_cnt_d = busy_cnt_q;
        if (inc) busy_cnt_d = busy_cnt_d + CNT_ONE;
        if (dec) busy_cnt_d = busy_cnt_d - CNT_ONE;

        sb_err_d = sb_err_q
                 || (mark_ok && busy_q[mark_addr] && !same)
                 || (clr_ok && !busy_q[wb_addr] && !same);
    end

    always_comb begin
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[field_lsb(i, AW) +: AW];
            rd_busy[i] = busy_q[ra]
                && !(wb_we && wb_addr == ra
                     && !(mark_ok && mark_addr == ra));
            if (ZR && ra == ZERO_IDX) rd_busy[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
            sb_err_q   <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
            sb_err_q   <= sb_err_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign sb_err   = sb_err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with two write ports, full write-to-read
// bypass on every read port, and a busy scoreboard for long-latency ops.
module regfile_scoreboard
    import cpu_pkg::*;
#(
    parameter int  DATA_W   = DATA_W_DEF,
    parameter int  NUM_REGS = NUM_REGS_DEF,
    parameter int  NUM_RD   = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_we,
    input  logic [AW-1:0]            wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_we,
    input  logic [AW-1:0]            wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     mark_en,
    input  logic [AW-1:0]            mark_addr,
    output logic [AW:0]              busy_cnt,
    output logic                     sb_err
);

    localparam bit            ZR       = (ZERO_REG != 0);
    localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic          wa_ok;
    logic          wb_ok;
    logic [AW-1:0] ra;

    // Port A is applied last so it wins a same-address collision.
    always_comb begin
        wa_ok  = wa_we && !(ZR && wa_addr == ZERO_IDX);
        wb_ok  = wb_we && !(ZR && wb_addr == ZERO_IDX);
        regs_d = regs_q;
        if (wb_ok) regs_d[wb_addr] = wb_data;
        if (wa_ok) regs_d[wa_addr] = wa_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = '0;
        ra      = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = rd_addr[field_lsb(i, AW) +: AW];
            if (ZR && ra == ZERO_IDX)
                rd_data[field_lsb(i, DATA_W) +: DATA_W] = '0;
            else if (wa_we && wa_addr == ra)
                rd_data[field_lsb(i, DATA_W) +: DATA_W] = wa_data;
            else if (wb_we && wb_addr == ra)
                rd_data[field_lsb(i, DATA_W) +: DATA_W] = wb_data;
            else
                rd_data[field_lsb(i, DATA_W) +: DATA_W] = regs_q[ra];
        end
    end

    busy_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .rd_busy   (rd_busy),
        .busy_cnt  (busy_cnt),
        .sb_err    (sb_err)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: stimulus queues expected values
// tagged with a cycle, a negedge monitor pops and compares them.
module tb_regfile_scoreboard;

    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int NRD = 2;
    localparam int AW  = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset;
    logic [NRD*AW-1:0]  rd_addr;
    logic [NRD*DW-1:0]  rd_data;
    logic [NRD-1:0]     rd_busy;
    logic               wa_we;
    logic [AW-1:0]      wa_addr;
    logic [DW-1:0]      wa_data;
    logic               wb_we;
    logic [AW-1:0]      wb_addr;
    logic [DW-1:0]      wb_data;
    logic               mark_en;
    logic [AW-1:0]      mark_addr;
    logic [AW:0]        busy_cnt;
    logic               sb_err;

    regfile_scoreboard #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wa_we     (wa_we),
        .wa_addr   (wa_addr),
        .wa_data   (wa_data),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .mark_en   (mark_en),
        .mark_addr (mark_addr),
        .busy_cnt  (busy_cnt),
        .sb_err    (sb_err)
    );

    typedef enum int {K_DATA, K_BUSY, K_CNT, K_ERR} kind_e;

    typedef struct {
        string       name;
        kind_e       kind;
        int          idx;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
        reset   = 1'b0;
        wa_we   = 1'b0;
        wb_we   = 1'b0;
        mark_en = 1'b0;
    endtask

    task automatic rd(input int p, input int a);
        rd_addr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic wa(input int a, input logic [31:0] d);
        wa_we   = 1'b1;
        wa_addr = a[AW-1:0];
        wa_data = d;
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        wb_we   = 1'b1;
        wb_addr = a[AW-1:0];
        wb_data = d;
    endtask

    task automatic mark(input int a);
        mark_en   = 1'b1;
        mark_addr = a[AW-1:0];
    endtask

    task automatic push_exp(input string n, input kind_e k,
                            input int i, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.idx  = i;
        e.val  = v;
        e.cyc  = cyc;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] actual(input kind_e k, input int i);
        case (k)
            K_DATA:  return rd_data[i*DW +: DW];
            K_BUSY:  return {31'b0, rd_busy[i]};
            K_CNT:   return 32'(busy_cnt);
            default: return {31'b0, sb_err};
        endcase
    endfunction

    initial begin : monitor
        exp_t        e;
        logic [31:0] got;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                checks++;
                if (e.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: sample missed (cycle %0d, now %0d)",
                             e.name, e.cyc, cyc);
                end else begin
                    got = actual(e.kind, e.idx);
                    if (got !== e.val) begin
                        errors++;
                        $display("FAIL %s: got %h expected %h",
                                 e.name, got, e.val);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset     = 1'b1;
        rd_addr   = '0;
        wa_we     = 1'b0;
        wa_addr   = '0;
        wa_data   = '0;
        wb_we     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        mark_en   = 1'b0;
        mark_addr = '0;
        repeat (2) @(posedge clk);

        for (int r = 0; r < NR; r++) begin
            step();
            rd(0, r);
            rd(1, NR - 1 - r);
            push_exp("rst_data0", K_DATA, 0, 32'h0);
            push_exp("rst_data1", K_DATA, 1, 32'h0);
            push_exp("rst_busy0", K_BUSY, 0, 32'h0);
            push_exp("rst_busy1", K_BUSY, 1, 32'h0);
        end
        push_exp("rst_cnt", K_CNT, 0, 32'h0);
        push_exp("rst_err", K_ERR, 0, 32'h0);

        step(); wa(5, 32'h1234_5678); rd(0, 5);
        push_exp("bypass_a", K_DATA, 0, 32'h1234_5678);
        step(); rd(0, 5);
        push_exp("stored_a", K_DATA, 0, 32'h1234_5678);

        step(); wa(0, 32'hFFFF_FFFF); wb(0, 32'hFFFF_FFFF); rd(0, 0);
        push_exp("zero_bypass", K_DATA, 0, 32'h0);
        step(); mark(0); rd(0, 0);
        push_exp("zero_store", K_DATA, 0, 32'h0);
        step();
        push_exp("zero_cnt", K_CNT, 0, 32'h0);
        push_exp("zero_busy", K_BUSY, 0, 32'h0);
        push_exp("zero_err", K_ERR, 0, 32'h0);

        step(); mark(8); rd(1, 8);
        push_exp("pre_busy8", K_BUSY, 1, 32'h0);
        step();
        push_exp("busy8", K_BUSY, 1, 32'h1);
        push_exp("cnt_one", K_CNT, 0, 32'h1);
        step(); wb(8, 32'h0000_ABCD);
        push_exp("wb_byp_busy", K_BUSY, 1, 32'h0);
        push_exp("wb_byp_data", K_DATA, 1, 32'h0000_ABCD);
        push_exp("wb_cnt_hold", K_CNT, 0, 32'h1);
        step();
        push_exp("clr_cnt", K_CNT, 0, 32'h0);
        push_exp("clr_err", K_ERR, 0, 32'h0);
        push_exp("clr_busy", K_BUSY, 1, 32'h0);
        push_exp("clr_data", K_DATA, 1, 32'h0000_ABCD);

        step(); mark(3);
        step(); wa(3, 32'h11); wb(3, 32'h22); rd(0, 3);
        push_exp("ab_bypass", K_DATA, 0, 32'h11);
        push_exp("ab_cnt", K_CNT, 0, 32'h1);
        step(); rd(0, 3);
        push_exp("ab_store", K_DATA, 0, 32'h11);
        push_exp("ab_cnt_clr", K_CNT, 0, 32'h0);

        step(); mark(9); rd(1, 9);
        step(); mark(9); wb(9, 32'h99);
        push_exp("remark_busy", K_BUSY, 1, 32'h1);
        push_exp("remark_data", K_DATA, 1, 32'h99);
        push_exp("remark_cnt0", K_CNT, 0, 32'h1);
        step();
        push_exp("remark_held", K_BUSY, 1, 32'h1);
        push_exp("remark_cnt1", K_CNT, 0, 32'h1);
        push_exp("remark_err", K_ERR, 0, 32'h0);
        push_exp("remark_store", K_DATA, 1, 32'h99);
        step(); wb(9, 32'h9A);
        push_exp("done9_busy", K_BUSY, 1, 32'h0);
        push_exp("done9_data", K_DATA, 1, 32'h9A);

        step(); mark(10);
        push_exp("multi_cnt0", K_CNT, 0, 32'h0);
        step(); mark(11);
        push_exp("multi_cnt1", K_CNT, 0, 32'h1);
        step(); wb(10, 32'hAA); mark(12);
        push_exp("multi_cnt2", K_CNT, 0, 32'h2);
        step(); wb(11, 32'hBB);
        push_exp("multi_cnt2b", K_CNT, 0, 32'h2);
        step(); wb(12, 32'hCC);
        push_exp("multi_cnt1b", K_CNT, 0, 32'h1);
        step();
        push_exp("multi_cnt0b", K_CNT, 0, 32'h0);
        push_exp("multi_err", K_ERR, 0, 32'h0);

        step(); wb(4, 32'h44);
        step();
        push_exp("err_wb", K_ERR, 0, 32'h1);
        push_exp("err_wb_cnt", K_CNT, 0, 32'h0);
        step();
        push_exp("err_sticky", K_ERR, 0, 32'h1);

        step(); reset = 1'b1; mark(7);
        step(); rd(0, 5); rd(1, 7);
        push_exp("rst2_err", K_ERR, 0, 32'h0);
        push_exp("rst2_cnt", K_CNT, 0, 32'h0);
        push_exp("rst2_data", K_DATA, 0, 32'h0);
        push_exp("rst2_busy7", K_BUSY, 1, 32'h0);

        step(); mark(7);
        step(); mark(7);
        push_exp("dbl_cnt", K_CNT, 0, 32'h1);
        push_exp("dbl_err0", K_ERR, 0, 32'h0);
        step();
        push_exp("dbl_err", K_ERR, 0, 32'h1);
        push_exp("dbl_cnt1", K_CNT, 0, 32'h1);

        step(); reset = 1'b1; mark(20); wa(21, 32'h55);
        step(); rd(0, 21); rd(1, 20);
        push_exp("rst3_data", K_DATA, 0, 32'h0);
        push_exp("rst3_busy", K_BUSY, 1, 32'h0);
        push_exp("rst3_cnt", K_CNT, 0, 32'h0);
        push_exp("rst3_err", K_ERR, 0, 32'h0);

        step();
        repeat (3) @(posedge clk);
        if (sbq.size() != 0) begin
            errors += sbq.size();
            $display("FAIL drain: %0d expectations never compared",
                     sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
